// File: rtl/shape_read.sv
// shape_read: walks shape records in RAM, reassembles five-word records and presents them on a valid/ready port.
// Latency: start -> first shape_valid in 7 cycles; handshake -> next shape_valid in 7 cycles.
// Backpressure: shape outputs hold while shape_ready is low; no reads are issued while stalled.
// Option SHAPE_READ_SKIP_EMPTY_EN: records whose ty is 0 are dropped without being presented.
module shape_read #(
    parameter int DATAB = 3,
    parameter int CORDW = 9,
    parameter int ADDRW = 20,
    parameter int DATAW = 12,
    parameter int NUMW  = DATAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUMW-1:0]  count,
    input  logic [ADDRW-1:0] ram_address_offset,
    output logic [ADDRW-1:0] ram_address,
    output logic             ram_enable,
    input  logic [DATAW-1:0] ram_data,
    output logic             busy,
    output logic             done,
    output logic             shape_valid,
    input  logic             shape_ready,
    output logic [NUMW-1:0]  shape_id,
    output logic [DATAW-1:0] ty,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y,
    output logic [DATAW-1:0] size,
    output logic [DATAW-1:0] rotate
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, EMIT} state_t;
    localparam logic [2:0] LAST_WORD = 3'd4;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [NUMW-1:0]  id_q, id_d, count_q, count_d;
    logic [ADDRW-1:0] offset_q, offset_d, addr_q, addr_d;
    logic             en_q, en_d, busy_q, busy_d, done_q, done_d, vld_q, vld_d;
    logic [DATAW-1:0] ty_q, ty_d, size_q, size_d, rot_q, rot_d;
    logic [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic             last_rec;
    logic             advance;

    // Address arithmetic wraps modulo 2^ADDRW by construction.
    function automatic logic [ADDRW-1:0] rec_addr(input logic [NUMW-1:0] rid,
                                                  input logic [ADDRW-1:0] base,
                                                  input logic [2:0] word);
        return (ADDRW'(rid) << DATAB) + base + ADDRW'(word);
    endfunction

    assign last_rec = (id_q == count_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        count_d  = count_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        vld_d    = 1'b0;
        ty_d     = ty_q;
        x_d      = x_q;
        y_d      = y_q;
        size_d   = size_q;
        rot_d    = rot_q;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d  = count;
                    offset_d = ram_address_offset;
                    id_d     = '0;
                    ptr_d    = '0;
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        en_d    = 1'b1;
                        addr_d  = rec_addr('0, ram_address_offset, 3'd0);
                    end
                end
            end
            ISSUE: begin
                // Read data lags the issued word by one cycle.
                case (ptr_q)
                    3'd1:    ty_d   = ram_data;
                    3'd2:    x_d    = ram_data[CORDW-1:0];
                    3'd3:    y_d    = ram_data[CORDW-1:0];
                    3'd4:    size_d = ram_data;
                    default: ;
                endcase
                if (ptr_q == LAST_WORD) begin
                    state_d = CAPTURE;
                end else begin
                    ptr_d  = ptr_q + 3'd1;
                    en_d   = 1'b1;
                    addr_d = rec_addr(id_q, offset_q, ptr_q + 3'd1);
                end
            end
            CAPTURE: begin
                rot_d = ram_data;
`ifdef SHAPE_READ_SKIP_EMPTY_EN
                if (ty_q == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d = EMIT;
                    vld_d   = 1'b1;
                end
`else
                state_d = EMIT;
                vld_d   = 1'b1;
`endif
            end
            EMIT: begin
                vld_d = 1'b1;
                if (shape_ready) begin
                    vld_d   = 1'b0;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            if (last_rec) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                id_d    = id_q + 1'b1;
                ptr_d   = '0;
                state_d = ISSUE;
                en_d    = 1'b1;
                addr_d  = rec_addr(id_q + 1'b1, offset_q, 3'd0);
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            count_q  <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_q    <= 1'b0;
            ty_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            size_q   <= '0;
            rot_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            ty_q     <= ty_d;
            x_q      <= x_d;
            y_q      <= y_d;
            size_q   <= size_d;
            rot_q    <= rot_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_enable  = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign shape_valid = vld_q;
    assign shape_id    = id_q;
    assign ty          = ty_q;
    assign x           = x_q;
    assign y           = y_q;
    assign size        = size_q;
    assign rotate      = rot_q;
endmodule

// File: tb/tb_shape_read.sv
// Directed bench for shape_read: table of scan vectors replayed through one monitor, plus reset-abort sequence.
module tb_shape_read;
    localparam int CORDW  = 9;
    localparam int ADDRW  = 20;
    localparam int DATAW  = 12;
    localparam int NUMW   = 12;
    localparam int BUDGET = 400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             shape_ready = 1'b0;
    logic [NUMW-1:0]  count = '0;
    logic [ADDRW-1:0] ram_address_offset = '0;
    logic [ADDRW-1:0] ram_address;
    logic             ram_enable, busy, done, shape_valid;
    logic [DATAW-1:0] ram_data = '0;
    logic [NUMW-1:0]  shape_id;
    logic [DATAW-1:0] ty, size, rotate;
    logic [CORDW-1:0] x, y;
    logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [11:0] ty, xw, yw, sz, rot;
        logic [8:0]  ex, ey;
    } rec_t;
    typedef struct {
        string       nm;
        int          cnt;
        logic [19:0] off;
        int          stall;
        int          rsel;
        bit          poke;
    } vec_t;

    rec_t tbl [4];
    vec_t vec [6];

    shape_read dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count),
        .ram_address_offset(ram_address_offset), .ram_address(ram_address),
        .ram_enable(ram_enable), .ram_data(ram_data), .busy(busy), .done(done),
        .shape_valid(shape_valid), .shape_ready(shape_ready), .shape_id(shape_id),
        .ty(ty), .x(x), .y(y), .size(size), .rotate(rotate)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_enable) ram_data <= mem[ram_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int cnt, input logic [19:0] off,
                                input int stall, input int rsel, input bit poke);
        vec_t v;
        v.nm = nm; v.cnt = cnt; v.off = off; v.stall = stall; v.rsel = rsel; v.poke = poke;
        return v;
    endfunction

    function automatic rec_t rec_of(input int rsel, input int n);
        if (rsel >= 0) return tbl[rsel];
        if (n < 0) return tbl[0];
        return tbl[n % 4];
    endfunction

    function automatic bit emitted(input logic [11:0] t);
`ifdef SHAPE_READ_SKIP_EMPTY_EN
        return t != 12'd0;
`else
        return (t == t);
`endif
    endfunction

    task automatic run_scan(input vec_t v);
        int cyc, en_n, done_n, done_cyc, last_hs, last_en, sc, prev_id, ovl, unstable, emit_n, exp_id, emit_total;
        int expq[$];
        bit holding;
        rec_t r;
        logic [19:0] exp_a;
        logic [4:0][11:0] wd;
        logic [65:0] snap;
        for (int n = 0; n < v.cnt; n++) begin
            r = rec_of(v.rsel, n);
            wd = {r.rot, r.sz, r.yw, r.xw, r.ty};
            for (int w = 0; w < 5; w++) mem[v.off + 20'(n * 8 + w)] = wd[w];
            if (emitted(r.ty)) expq.push_back(n);
        end
        emit_total = expq.size();
        en_n = 0; done_n = 0; done_cyc = -1; last_hs = -1; last_en = -1;
        sc = 0; prev_id = -1; ovl = 0; unstable = 0; emit_n = 0; holding = 1'b0; snap = '0;
        @(negedge clk);
        start = 1'b1; count = NUMW'(v.cnt); ram_address_offset = v.off;
        shape_ready = (v.stall == 0);
        @(negedge clk);
        cyc = 1;
        chk({v.nm, "/busy_c1"}, 32'(busy), 32'(v.cnt > 0));
        while (cyc < BUDGET) begin
            start = 1'b0;
            if (done) begin
                done_n++; done_cyc = cyc;
                chk({v.nm, "/busy_at_done"}, 32'(busy), 32'd0);
            end
            if (shape_valid && done) ovl++;
            if (ram_enable) begin
                exp_a = v.off + 20'((en_n / 5) * 8 + en_n % 5);
                chk({v.nm, "/addr"}, 32'(ram_address), 32'(exp_a));
                en_n++; last_en = cyc;
            end
            if (shape_valid) begin
                if (!holding) begin
                    holding = 1'b1; unstable = 0; sc = 0;
                    snap = {shape_id, ty, x, y, size, rotate};
                    exp_id = (expq.size() > 0) ? expq.pop_front() : -1;
                    r = rec_of(v.rsel, exp_id);
                    chk({v.nm, "/id"}, 32'(shape_id), 32'(exp_id));
                    chk({v.nm, "/ty"}, 32'(ty), 32'(r.ty));
                    chk({v.nm, "/x"}, 32'(x), 32'(r.ex));
                    chk({v.nm, "/y"}, 32'(y), 32'(r.ey));
                    chk({v.nm, "/size"}, 32'(size), 32'(r.sz));
                    chk({v.nm, "/rotate"}, 32'(rotate), 32'(r.rot));
                    if (emit_n == 0 && exp_id == 0) chk({v.nm, "/first_valid_cycle"}, 32'(cyc), 32'd7);
                    if (last_hs >= 0 && exp_id == prev_id + 1)
                        chk({v.nm, "/record_gap"}, 32'(cyc - last_hs), 32'd7);
                    if (v.poke && emit_n == 0) begin
                        start = 1'b1; count = NUMW'(v.cnt + 5);
                    end
                    prev_id = exp_id; emit_n++;
                end else if ({shape_id, ty, x, y, size, rotate} !== snap) begin
                    unstable++;
                end
                shape_ready = (sc >= v.stall);
                sc++;
                if (shape_ready) begin
                    holding = 1'b0; last_hs = cyc;
                    chk({v.nm, "/stable_while_stalled"}, 32'(unstable), 32'd0);
                end
            end else begin
                shape_ready = (v.stall == 0);
            end
            if (done_n > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({v.nm, "/enable_cycles"}, 32'(en_n), 32'(5 * v.cnt));
        chk({v.nm, "/shapes_emitted"}, 32'(emit_n), 32'(emit_total));
        chk({v.nm, "/done_pulses"}, 32'(done_n), 32'd1);
        chk({v.nm, "/done_valid_overlap"}, 32'(ovl), 32'd0);
        if (v.cnt == 0) chk({v.nm, "/done_cycle"}, 32'(done_cyc), 32'd1);
        else if (prev_id == v.cnt - 1) chk({v.nm, "/done_after_hs"}, 32'(done_cyc), 32'(last_hs + 1));
        else chk({v.nm, "/done_after_capture"}, 32'(done_cyc), 32'(last_en + 2));
    endtask

    initial begin
        int quiet;
        tbl[0] = '{ty: 12'd3,     xw: 12'h05A, yw: 12'h0C8, sz: 12'd16,  rot: 12'd90,  ex: 9'd90,   ey: 9'd200};
        tbl[1] = '{ty: 12'd0,     xw: 12'h123, yw: 12'h045, sz: 12'd7,   rot: 12'd45,  ex: 9'h123,  ey: 9'h045};
        tbl[2] = '{ty: 12'd5,     xw: 12'hE5A, yw: 12'h3FF, sz: 12'hFFF, rot: 12'h800, ex: 9'h05A,  ey: 9'h1FF};
        tbl[3] = '{ty: 12'hABC,   xw: 12'h1FF, yw: 12'h200, sz: 12'd1,   rot: 12'd0,   ex: 9'h1FF,  ey: 9'h000};
        vec[0] = mk("single",    1, 20'h00100, 0,  -1, 1'b0);
        vec[1] = mk("backpress", 3, 20'h02000, 10, -1, 1'b1);
        vec[2] = mk("zero",      0, 20'h00300, 0,  -1, 1'b0);
        vec[3] = mk("wrap",      2, 20'hFFFFC, 0,  -1, 1'b0);
        vec[4] = mk("allempty",  2, 20'h00500, 0,  1,  1'b0);
        vec[5] = mk("four",      4, 20'h00040, 2,  -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset/ram_enable", 32'(ram_enable), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/shape_valid", 32'(shape_valid), 32'd0);
        chk("reset/fields", 32'(|{shape_id, ty, x, y, size, rotate, ram_address}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_scan(vec[i]);

        // Abort during ISSUE with ptr=2; ty already holds word 0 of the record.
        @(negedge clk);
        start = 1'b1; count = 12'd2; ram_address_offset = 20'h00100; shape_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort/addr_ptr2", 32'(ram_address), 32'h102);
        chk("abort/ty_loaded", 32'(ty), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort/ram_enable", 32'(ram_enable), 32'd0);
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/shape_valid", 32'(shape_valid), 32'd0);
        chk("abort/fields", 32'(|{shape_id, ty, x, y, size, rotate, ram_address}), 32'd0);
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || ram_enable || shape_valid) quiet++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || ram_enable || shape_valid) quiet++;
        end
        chk("abort/no_activity_after_reset", 32'(quiet), 32'd0);
        run_scan(mk("after_reset", 2, 20'h00100, 1, -1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
